hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order vector pipeline. It replaces the single-stage RA/RB-vs-last-RD comparator with a registered scoreboard of DEPTH in-flight producer stages, and drives per-operand forwarding selects. It adds load-use stalls and partial-write (ppp) stalls, and keeps a saturating stall counter. It sits beside the decoder in ID and feeds the operand forwarding muxes and the IF/ID hold logic.

## Interface
- REG_ADDRESS_LENGTH, 5, register address width.
- DEPTH, 2, number of post-ID stages tracked; stage DEPTH is writeback. Legal range 1..8.
- LOAD_READY_STAGE, 2, first stage whose load result can be forwarded. Legal range 1..DEPTH.
- ZERO_REG_EN, 1, when 1, register 0 never creates a hazard.
- SEL_W, $clog2(DEPTH+1), width of the forwarding selects.
- CNT_W, 16, width of the stall counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- flush  in  1  branch taken; the ID instruction is squashed this cycle.
- id_ra, id_rb  in  REG_ADDRESS_LENGTH each  source operand addresses.
- id_ra_used, id_rb_used  in  1 each  the operand is actually read.
- id_rd  in  REG_ADDRESS_LENGTH  destination address.
- id_wr_en  in  1  the instruction writes id_rd.
- id_is_load  in  1  the result comes from DMEM/NIC, not the ALU.
- id_wr_full  in  1  the write covers all bytes (ppp selects the full register).
- stall  out  1  hold PC and IF/ID, and insert a bubble.
- fwd_sel_a, fwd_sel_b  out  SEL_W each  0 = register file, k = forward from stage k.
- stall_count  out  CNT_W  number of stall cycles, saturating.

## Operation
- Each scoreboard entry k (1..DEPTH) holds: valid, rd, wr_en, is_load, full.
- Effective ID validity: id_eff = id_valid & ~flush.
- Match rule, evaluated per operand X in {a, b}. Entry k matches when all of the following hold:
  - X is used and id_eff is 1;
  - entry k has valid and wr_en set;
  - entry k's rd equals the operand address;
  - the address is not 0, or ZERO_REG_EN is 0.
- Resolution uses only the youngest match, i.e. the smallest k; older matches are ignored.
  - The youngest match is forwardable if full=1 and (is_load=0 or k >= LOAD_READY_STAGE). In that case fwd_sel_X = k.
  - If the youngest match is not forwardable, the operand is blocked.
  - With no match, fwd_sel_X = 0.
- stall = operand a blocked OR operand b blocked.
- While stall=1, both fwd selects are still driven as computed; the consumer ignores them.
- Advance on every clock:
  - entry k+1 takes entry k;
  - entry DEPTH is dropped (retired);
  - entry 1 takes the ID instruction if id_eff and not stall; otherwise entry 1 takes a bubble (valid=0).
- stall_count increments on every cycle with stall=1 and holds at all-ones.
- Flush with a pending hazard: flush wins, so stall=0, both selects are 0, and no entry is created.
- A partial-write producer blocks its consumer until it retires; the register file read after the writeback edge is then correct.

## Timing
- stall, fwd_sel_a and fwd_sel_b are combinational from the ID inputs and the registered scoreboard. There is no added latency, and they are valid within the same cycle.
- The scoreboard and stall_count update on posedge clk only.
- The instruction in ID during a stall re-presents its inputs the next cycle. The block does not latch ID inputs.
- Load-use with LOAD_READY_STAGE=L: a consumer directly behind a load stalls L-1 cycles.
- Partial write in stage 1: the consumer directly behind it stalls DEPTH cycles.
- Reset (rst=0, asynchronous, effective at any point, including mid-stall):
  - all entries go invalid immediately and stall_count goes to 0;
  - with all entries invalid, stall=0 and both selects are 0;
  - normal operation resumes on the first edge after rst returns to 1.

## Test plan
- ALU back-to-back, DEPTH=2: write r3, then read r3 as RA → fwd_sel_a=1, stall=0. A second reader one cycle later → fwd_sel_a=2. A third reader → 0.
- Load-use, L=2: load r4, then read r4 as RB → stall=1 for one cycle, then fwd_sel_b=2, stall=0. stall_count=1.
- Double producer: write r5, write r5, read r5 → fwd_sel_a=1 (youngest wins). Same reader with both operands r5 → both selects=1.
- Partial write: r6 with id_wr_full=0, then read r6 → stall for 2 cycles, then fwd_sel_a=0. stall_count=2.
- Zero register and flush:
  - producer r0, then reader r0 → fwd_sel=0, stall=0;
  - load r7, then reader r7 with flush=1 → stall=0, and the following cycle shows no entry for the squashed instruction.
- Reset mid-stall: during a load-use stall, pull rst low between edges → stall drops to 0 immediately and stall_count=0. After release, a reader of r4 → fwd_sel_b=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - registered hazard scoreboard with per-operand forwarding selects
module hazard_scoreboard #(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int DEPTH              = 2,
    parameter int LOAD_READY_STAGE   = 2,
    parameter int ZERO_REG_EN        = 1,
    parameter int SEL_W              = $clog2(DEPTH + 1),
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid_i,
    input  logic                          flush_i,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_ra_i,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rb_i,
    input  logic                          id_ra_used_i,
    input  logic                          id_rb_used_i,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd_i,
    input  logic                          id_wr_en_i,
    input  logic                          id_is_load_i,
    input  logic                          id_wr_full_i,
    output logic                          stall_o,
    output logic [SEL_W-1:0]              fwd_sel_a_o,
    output logic [SEL_W-1:0]              fwd_sel_b_o,
    output logic [CNT_W-1:0]              stall_count_o
);

    // Index i holds pipeline stage i+1; index DEPTH-1 is writeback.
    logic [DEPTH-1:0]              valid_q;
    logic [DEPTH-1:0]              wr_en_q;
    logic [DEPTH-1:0]              is_load_q;
    logic [DEPTH-1:0]              full_q;
    logic [REG_ADDRESS_LENGTH-1:0] rd_q [DEPTH];
    logic [CNT_W-1:0]              stall_count_q;
    logic [CNT_W-1:0]              stall_count_d;
    logic                          valid_d;

    logic                          id_eff;
    logic [DEPTH-1:0]              hit_a;
    logic [DEPTH-1:0]              hit_b;
    logic [DEPTH-1:0]              fwdable;
    logic                          blk_a;
    logic                          blk_b;
    logic [SEL_W-1:0]              sel_a;
    logic [SEL_W-1:0]              sel_b;

    assign id_eff = id_valid_i & ~flush_i;

    always_comb begin
        hit_a   = '0;
        hit_b   = '0;
        fwdable = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = id_eff && id_ra_used_i && valid_q[i] && wr_en_q[i] && (rd_q[i] == id_ra_i)
                       && ((id_ra_i != '0) || (ZERO_REG_EN == 0));
            hit_b[i] = id_eff && id_rb_used_i && valid_q[i] && wr_en_q[i] && (rd_q[i] == id_rb_i)
                       && ((id_rb_i != '0) || (ZERO_REG_EN == 0));
            fwdable[i] = full_q[i] && (!is_load_q[i] || ((i + 1) >= LOAD_READY_STAGE));
        end
    end

    // Walk oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        blk_a = 1'b0;
        blk_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_a[i]) begin
                blk_a = !fwdable[i];
                sel_a = fwdable[i] ? SEL_W'(i + 1) : '0;
            end
            if (hit_b[i]) begin
                blk_b = !fwdable[i];
                sel_b = fwdable[i] ? SEL_W'(i + 1) : '0;
            end
        end
    end

    assign stall_o       = blk_a | blk_b;
    assign fwd_sel_a_o   = sel_a;
    assign fwd_sel_b_o   = sel_b;
    assign stall_count_o = stall_count_q;

    always_comb begin
        valid_d       = id_eff & ~stall_o;
        stall_count_d = stall_count_q;
        if (stall_o && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            wr_en_q       <= '0;
            is_load_q     <= '0;
            full_q        <= '0;
            stall_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q[0]    <= valid_d;
            wr_en_q[0]    <= id_wr_en_i;
            is_load_q[0]  <= id_is_load_i;
            full_q[0]     <= id_wr_full_i;
            rd_q[0]       <= id_rd_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i]   <= valid_q[i-1];
                wr_en_q[i]   <= wr_en_q[i-1];
                is_load_q[i] <= is_load_q[i-1];
                full_q[i]    <= full_q[i-1];
                rd_q[i]      <= rd_q[i-1];
            end
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - queue-scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        flush;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic        id_ra_used;
    logic        id_rb_used;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic        id_is_load;
    logic        id_wr_full;
    logic        stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    typedef struct {
        string tag;
        int    st;
        int    a;
        int    b;
        int    cnt;
        bit    chk_a;
        bit    chk_b;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDRESS_LENGTH(5),
        .DEPTH(2),
        .LOAD_READY_STAGE(2),
        .ZERO_REG_EN(1),
        .SEL_W(2),
        .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid_i   (id_valid),
        .flush_i      (flush),
        .id_ra_i      (id_ra),
        .id_rb_i      (id_rb),
        .id_ra_used_i (id_ra_used),
        .id_rb_used_i (id_rb_used),
        .id_rd_i      (id_rd),
        .id_wr_en_i   (id_wr_en),
        .id_is_load_i (id_is_load),
        .id_wr_full_i (id_wr_full),
        .stall_o      (stall),
        .fwd_sel_a_o  (fwd_sel_a),
        .fwd_sel_b_o  (fwd_sel_b),
        .stall_count_o(stall_count)
    );

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input int ra, input logic rau,
                         input int rb, input logic rbu, input int rd, input logic wr,
                         input logic ld, input logic full);
        id_valid   = v;
        flush      = fl;
        id_ra      = 5'(ra);
        id_ra_used = rau;
        id_rb      = 5'(rb);
        id_rb_used = rbu;
        id_rd      = 5'(rd);
        id_wr_en   = wr;
        id_is_load = ld;
        id_wr_full = full;
    endtask

    task automatic push_exp(input string tag, input int st, input int a, input int b,
                            input bit ca, input bit cb);
        exp_t e;
        e.tag = tag; e.st = st; e.a = a; e.b = b; e.cnt = model_cnt;
        e.chk_a = ca; e.chk_b = cb;
        exp_q.push_back(e);
        if (st != 0) model_cnt++;
    endtask

    // Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
    task automatic step(input string tag, input logic v, input logic fl, input int ra,
                        input logic rau, input int rb, input logic rbu, input int rd,
                        input logic wr, input logic ld, input logic full,
                        input int st, input int a, input int b, input bit ca, input bit cb);
        drive(v, fl, ra, rau, rb, rbu, rd, wr, ld, full);
        push_exp(tag, st, a, b, ca, cb);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check_eq({cur.tag, "_stall"}, int'(stall), cur.st);
            if (cur.chk_a) check_eq({cur.tag, "_sel_a"}, int'(fwd_sel_a), cur.a);
            if (cur.chk_b) check_eq({cur.tag, "_sel_b"}, int'(fwd_sel_b), cur.b);
            check_eq({cur.tag, "_count"}, int'(stall_count), cur.cnt);
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_stall", int'(stall), 0);
        check_eq("rst_sel_a", int'(fwd_sel_a), 0);
        check_eq("rst_sel_b", int'(fwd_sel_b), 0);
        check_eq("rst_count", int'(stall_count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   tag          v fl ra rau rb rbu rd wr ld fu   st a  b  ca cb
        step("alu_w3",    1, 0, 0, 0, 0, 0, 3, 1, 0, 1,   0, 0, 0, 1, 1);
        step("alu_r1",    1, 0, 3, 1, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 1);
        step("alu_r2",    1, 0, 3, 1, 0, 0, 0, 0, 0, 1,   0, 2, 0, 1, 1);
        step("alu_r3",    1, 0, 3, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);

        step("ld_w4",     1, 0, 0, 0, 0, 0, 4, 1, 1, 1,   0, 0, 0, 1, 1);
        step("ld_use",    1, 0, 0, 0, 4, 1, 0, 0, 0, 1,   1, 0, 0, 1, 0);
        step("ld_fwd",    1, 0, 0, 0, 4, 1, 0, 0, 0, 1,   0, 0, 2, 1, 1);

        step("dbl_w5a",   1, 0, 0, 0, 0, 0, 5, 1, 0, 1,   0, 0, 0, 1, 1);
        step("dbl_w5b",   1, 0, 0, 0, 0, 0, 5, 1, 0, 1,   0, 0, 0, 1, 1);
        step("dbl_rd",    1, 0, 5, 1, 5, 1, 0, 0, 0, 1,   0, 1, 1, 1, 1);

        step("pw_w6",     1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0, 1, 1);
        step("pw_st1",    1, 0, 6, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1);
        step("pw_st2",    1, 0, 6, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1);
        step("pw_rf",     1, 0, 6, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);

        step("z_w0",      1, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 1);
        step("z_r0",      1, 0, 0, 1, 0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 1);

        step("fl_ld7",    1, 0, 0, 0, 0, 0, 7, 1, 1, 1,   0, 0, 0, 1, 1);
        step("fl_sq",     1, 1, 0, 0, 7, 1, 7, 1, 0, 1,   0, 0, 0, 1, 1);
        step("fl_after",  1, 0, 7, 1, 0, 0, 0, 0, 0, 1,   0, 2, 0, 1, 1);

        step("rs_ld4",    1, 0, 0, 0, 0, 0, 4, 1, 1, 1,   0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 1);
        push_exp("rs_stall", 1, 0, 0, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rs_mid_stall", int'(stall), 0);
        check_eq("rs_mid_count", int'(stall_count), 0);
        check_eq("rs_mid_sel_a", int'(fwd_sel_a), 0);
        check_eq("rs_mid_sel_b", int'(fwd_sel_b), 0);
        model_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("rs_after",  1, 0, 0, 0, 4, 1, 0, 0, 0, 1,   0, 0, 0, 1, 1);
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);

        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
